y_fetch_queue: RTL and testbench

Parametrised instruction-fetch front end for the y-series MIPS datapath, replacing the bare PC-plus-instruction-memory fetch with a buffered, handshaked unit. It owns the fetch PC, issues requests to instruction memory, holds fetched words in a DEPTH-entry queue, and presents {ins, pc, pc+4} to decode over a valid/ready interface. It supports entry-point load (the INT path) and branch/jump redirects, both of which flush the queue.

---
 rtl/y_cpu_pkg.sv | 17 +
 rtl/y_sync_fifo.sv | 62 ++++++
 rtl/y_fetch_queue.sv | 122 ++++++++++++
 tb/tb_y_fetch_queue.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/y_cpu_pkg.sv
// Shared definitions for the y-series CPU front end: instruction size, fetch-state encoding
// and an alignment helper.
package y_cpu_pkg;

    localparam int unsigned INSN_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } fetch_state_e;

    function automatic logic is_word_aligned(input logic [1:0] addr_lsb);
        return addr_lsb == 2'b00;
    endfunction

endpackage

// File: rtl/y_sync_fifo.sv
// Synchronous FIFO with push, pop and clear; the head entry is read combinationally.
// Clear wins over push/pop. The caller must not push when full or pop when empty.
module y_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wptr_q, rptr_q;
    logic [CW-1:0]    count_q;

    // Storage is reset so the head reads as zero until the first word lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_i && !clear_i) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else if (clear_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_i) begin
                wptr_q <= wptr_q + PW'(1);
            end
            if (pop_i) begin
                rptr_q <= rptr_q + PW'(1);
            end
            if (push_i && !pop_i) begin
                count_q <= count_q + CW'(1);
            end else if (pop_i && !push_i) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

    assign rdata_o = mem_q[rptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/y_fetch_queue.sv
// Buffered instruction-fetch front end: owns the fetch PC, requests words from instruction
// memory and queues {ins, pc, pc+4} for decode. Define FETCH_ALIGN_CHECK_EN to trap misaligned
// entry/redirect targets in a FAULT state.
module y_fetch_queue
    import y_cpu_pkg::*;
#(
    parameter int unsigned    AW            = 32,
    parameter int unsigned    DW            = 32,
    parameter int unsigned    DEPTH         = 4,
    parameter logic [AW-1:0]  ENTRY_DEFAULT = AW'(128)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       load_entry,
    input  logic [AW-1:0]              entry_point,
    input  logic                       redirect_valid,
    input  logic [AW-1:0]              redirect_pc,
    output logic                       imem_req,
    output logic [AW-1:0]              imem_addr,
    input  logic                       imem_ack,
    input  logic [DW-1:0]              imem_rdata,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DW-1:0]              out_ins,
    output logic [AW-1:0]              out_pc,
    output logic [AW-1:0]              out_pcp4,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       fault
);

    typedef struct packed {
        logic [DW-1:0] ins;
        logic [AW-1:0] pc;
    } fetch_entry_t;

    localparam int unsigned   CW     = $clog2(DEPTH + 1);
    localparam int unsigned   EW     = $bits(fetch_entry_t);
    localparam logic [AW-1:0] Step   = AW'(INSN_BYTES);
    localparam logic [1:0]    StIdle = IDLE;
    localparam logic [1:0]    StRun  = RUN;
`ifdef FETCH_ALIGN_CHECK_EN
    localparam logic [1:0]    StFault = FAULT;
`endif

    logic [AW-1:0]   pc_q, pc_d;
    logic [1:0]      state_q, state_d;
    logic            redirect_take, flush, push, pop;
    fetch_entry_t    wr_entry, rd_entry;
    logic [EW+AW-1:0] fifo_wdata, fifo_rdata;

`ifdef FETCH_ALIGN_CHECK_EN
    assign redirect_take = redirect_valid && (state_q != StFault);
    assign fault         = (state_q == StFault);
`else
    assign redirect_take = redirect_valid;
    assign fault         = 1'b0;
`endif

    assign flush     = load_entry || redirect_take;
    assign imem_req  = (state_q == StRun) && (count < CW'(DEPTH)) && !load_entry && !redirect_valid;
    assign imem_addr = pc_q;
    assign push      = imem_req && imem_ack;
    assign pop       = out_valid && out_ready && !flush;

    always_comb begin
        pc_d    = pc_q;
        state_d = state_q;
        if (load_entry) begin
            pc_d    = entry_point;
            state_d = StRun;
`ifdef FETCH_ALIGN_CHECK_EN
            if (!is_word_aligned(entry_point[1:0])) begin
                state_d = StFault;
            end
`endif
        end else if (redirect_take) begin
            pc_d = redirect_pc;
`ifdef FETCH_ALIGN_CHECK_EN
            if ((state_q == StRun) && !is_word_aligned(redirect_pc[1:0])) begin
                state_d = StFault;
            end
`endif
        end else if (push) begin
            pc_d = pc_q + Step;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= ENTRY_DEFAULT;
            state_q <= StIdle;
        end else begin
            pc_q    <= pc_d;
            state_q <= state_d;
        end
    end

    // pc+4 travels with the entry so the head needs no adder and reads zero out of reset.
    assign wr_entry   = '{ins: imem_rdata, pc: pc_q};
    assign fifo_wdata = {pc_q + Step, wr_entry};

    y_sync_fifo #(
        .WIDTH (EW + AW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (flush),
        .push_i  (push),
        .wdata_i (fifo_wdata),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .count_o (count)
    );

    assign rd_entry  = fifo_rdata[EW-1:0];
    assign out_valid = (count != '0);
    assign out_ins   = rd_entry.ins;
    assign out_pc    = rd_entry.pc;
    assign out_pcp4  = fifo_rdata[EW+AW-1:EW];

endmodule

// File: tb/tb_y_fetch_queue.sv
// Directed bench for y_fetch_queue: a queue-level model checked every cycle plus literal
// expectations for reset, entry load, backpressure, redirects, PC wrap and alignment faults.
module tb_y_fetch_queue;

    localparam logic [31:0] K32 = 32'h5A5A_0000;
    localparam logic [31:0] K8  = 32'hC0DE_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_entry, redirect_valid, imem_ack, out_ready;
    logic [31:0] entry_point, redirect_pc;
    logic        imem_req, out_valid, fault;
    logic [31:0] imem_addr, imem_rdata, out_ins, out_pc, out_pcp4;
    logic [2:0]  count;

    logic        w_load, w_redir, w_ack, w_ready;
    logic [7:0]  w_entry, w_redir_pc;
    logic        w_req, w_valid, w_fault;
    logic [7:0]  w_addr, w_out_pc, w_out_pcp4;
    logic [31:0] w_rdata, w_out_ins;
    logic [2:0]  w_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Instruction memory: word content is a fixed function of its address.
    assign imem_rdata = imem_addr ^ K32;
    assign w_rdata    = {24'h0, w_addr} ^ K8;

    y_fetch_queue #(.AW(32), .DW(32), .DEPTH(4)) u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .load_entry     (load_entry),
        .entry_point    (entry_point),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_ins        (out_ins),
        .out_pc         (out_pc),
        .out_pcp4       (out_pcp4),
        .count          (count),
        .fault          (fault)
    );

    y_fetch_queue #(.AW(8), .DW(32), .DEPTH(4)) u_dut8 (
        .clk            (clk),
        .rst_n          (rst_n),
        .load_entry     (w_load),
        .entry_point    (w_entry),
        .redirect_valid (w_redir),
        .redirect_pc    (w_redir_pc),
        .imem_req       (w_req),
        .imem_addr      (w_addr),
        .imem_ack       (w_ack),
        .imem_rdata     (w_rdata),
        .out_valid      (w_valid),
        .out_ready      (w_ready),
        .out_ins        (w_out_ins),
        .out_pc         (w_out_pc),
        .out_pcp4       (w_out_pcp4),
        .count          (w_count),
        .fault          (w_fault)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Behavioural model: a FIFO of fetched words, a PC and a mode (0 idle, 1 run, 2 fault).
    typedef struct {
        logic [31:0] ins;
        logic [31:0] pc;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] mpc = 32'd128;
    int          mstate = 0;
    bit          mon_en = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                logic        ereq;
                logic [31:0] ep4;
                ent_t        e;
                ereq = (mstate == 1) && (mq.size() < 4) && !load_entry && !redirect_valid;
                chk("m_req", 64'(imem_req), 64'(ereq));
                if (ereq) chk("m_addr", 64'(imem_addr), 64'(mpc));
                chk("m_valid", 64'(out_valid), 64'(mq.size() != 0));
                chk("m_count", 64'(count), 64'(mq.size()));
                if (mq.size() != 0) begin
                    ep4 = mq[0].pc + 32'd4;
                    chk("m_ins", 64'(out_ins), 64'(mq[0].ins));
                    chk("m_pc", 64'(out_pc), 64'(mq[0].pc));
                    chk("m_pcp4", 64'(out_pcp4), 64'(ep4));
                end
                chk("m_fault", 64'(fault), 64'(mstate == 2));

                if (load_entry) begin
                    mq.delete();
                    mpc    = entry_point;
                    mstate = 1;
`ifdef FETCH_ALIGN_CHECK_EN
                    if (entry_point[1:0] != 2'b00) mstate = 2;
`endif
                end else if (redirect_valid && mstate != 2) begin
                    mq.delete();
                    mpc = redirect_pc;
`ifdef FETCH_ALIGN_CHECK_EN
                    if (mstate == 1 && redirect_pc[1:0] != 2'b00) mstate = 2;
`endif
                end else begin
                    if (mq.size() != 0 && out_ready) void'(mq.pop_front());
                    if (ereq && imem_ack) begin
                        e.ins = mpc ^ K32;
                        e.pc  = mpc;
                        mq.push_back(e);
                        mpc = mpc + 32'd4;
                    end
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        load_entry = 1'b0; entry_point = '0; redirect_valid = 1'b0; redirect_pc = '0;
        imem_ack = 1'b1; out_ready = 1'b1;
        w_load = 1'b0; w_entry = '0; w_redir = 1'b0; w_redir_pc = '0;
        w_ack = 1'b1; w_ready = 1'b1;

        // Reset state
        tick(); tick(); tick();
        chk("rst_req", 64'(imem_req), 64'd0);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_fault", 64'(fault), 64'd0);
        chk("rst_ins", 64'(out_ins), 64'd0);
        chk("rst_pc", 64'(out_pc), 64'd0);
        chk("rst_pcp4", 64'(out_pcp4), 64'd0);
        chk("rst_addr", 64'(imem_addr), 64'h80);

        tick(); rst_n = 1'b1; mon_en = 1'b1;
        tick(); tick();
        chk("idle_req", 64'(imem_req), 64'd0);

        // Entry load, streaming at one word per cycle
        tick(); load_entry = 1'b1; entry_point = 32'h80;
        tick(); load_entry = 1'b0; #1;
        chk("ld_addr", 64'(imem_addr), 64'h80);
        chk("ld_req", 64'(imem_req), 64'd1);
        tick(); #1;
        chk("s0_pc", 64'(out_pc), 64'h80);
        chk("s0_pcp4", 64'(out_pcp4), 64'h84);
        chk("s0_ins", 64'(out_ins), 64'h5A5A_0080);
        tick(); #1; chk("s1_pc", 64'(out_pc), 64'h84);
        tick(); #1; chk("s2_pc", 64'(out_pc), 64'h88);

        // Full queue and backpressure
        tick(); out_ready = 1'b0; load_entry = 1'b1; entry_point = 32'h80;
        tick(); load_entry = 1'b0;
        tick(); tick(); tick(); tick(); #1;
        chk("full_count", 64'(count), 64'd4);
        chk("full_req", 64'(imem_req), 64'd0);
        chk("full_addr", 64'(imem_addr), 64'h90);
        chk("full_head", 64'(out_pc), 64'h80);
        out_ready = 1'b1;
        tick(); out_ready = 1'b0; #1;
        chk("pop_count", 64'(count), 64'd3);
        chk("pop_req", 64'(imem_req), 64'd1);
        chk("pop_addr", 64'(imem_addr), 64'h90);
        chk("pop_head", 64'(out_pc), 64'h84);
        tick(); #1;
        chk("fifth_count", 64'(count), 64'd4);
        chk("fifth_addr", 64'(imem_addr), 64'h94);

        // Redirect while a request is stalled
        tick(); load_entry = 1'b1; entry_point = 32'h80; imem_ack = 1'b1;
        tick(); load_entry = 1'b0;
        tick(); imem_ack = 1'b0; #1;
        chk("stall_req", 64'(imem_req), 64'd1);
        chk("stall_addr", 64'(imem_addr), 64'h84);
        tick(); #1;
        chk("hold_addr", 64'(imem_addr), 64'h84);
        tick(); redirect_valid = 1'b1; redirect_pc = 32'h200; #1;
        chk("rd_req_low", 64'(imem_req), 64'd0);
        tick(); redirect_valid = 1'b0; imem_ack = 1'b1; out_ready = 1'b1; #1;
        chk("rd_count", 64'(count), 64'd0);
        chk("rd_addr", 64'(imem_addr), 64'h200);
        tick(); #1;
        chk("rd_out_pc", 64'(out_pc), 64'h200);
        chk("rd_out_valid", 64'(out_valid), 64'd1);

        // Simultaneous load and redirect: load wins
        tick(); load_entry = 1'b1; entry_point = 32'h80;
        redirect_valid = 1'b1; redirect_pc = 32'h300;
        tick(); load_entry = 1'b0; redirect_valid = 1'b0; #1;
        chk("both_addr", 64'(imem_addr), 64'h80);
        chk("both_count", 64'(count), 64'd0);

        // Mixed ready/ack pattern, tracked by the model
        for (int i = 0; i < 16; i++) begin
            tick();
            out_ready = (i % 3) != 0;
            imem_ack  = (i % 4) != 1;
            redirect_valid = (i == 9);
            redirect_pc = 32'h1000;
        end
        tick(); redirect_valid = 1'b0; out_ready = 1'b1; imem_ack = 1'b1;

        // Misaligned redirect target
        tick(); redirect_valid = 1'b1; redirect_pc = 32'h202;
        tick(); redirect_valid = 1'b0; #1;
`ifdef FETCH_ALIGN_CHECK_EN
        chk("al_fault", 64'(fault), 64'd1);
        chk("al_req", 64'(imem_req), 64'd0);
        chk("al_count", 64'(count), 64'd0);
        tick(); redirect_valid = 1'b1; redirect_pc = 32'h400;
        tick(); redirect_valid = 1'b0; #1;
        chk("al_ign_fault", 64'(fault), 64'd1);
        chk("al_ign_addr", 64'(imem_addr), 64'h202);
        chk("al_ign_req", 64'(imem_req), 64'd0);
        tick(); load_entry = 1'b1; entry_point = 32'h81;
        tick(); load_entry = 1'b0; #1;
        chk("al_ld_fault", 64'(fault), 64'd1);
        tick(); load_entry = 1'b1; entry_point = 32'h80;
        tick(); load_entry = 1'b0; #1;
        chk("al_clr_fault", 64'(fault), 64'd0);
        chk("al_clr_addr", 64'(imem_addr), 64'h80);
        chk("al_clr_req", 64'(imem_req), 64'd1);
        tick(); #1;
        chk("al_resume_pc", 64'(out_pc), 64'h80);
`else
        chk("na_fault", 64'(fault), 64'd0);
        chk("na_addr", 64'(imem_addr), 64'h202);
        chk("na_req", 64'(imem_req), 64'd1);
        tick(); #1;
        chk("na_out_pc", 64'(out_pc), 64'h202);
`endif

        // PC wrap with an 8-bit address space
        tick(); w_load = 1'b1; w_entry = 8'hFC;
        tick(); w_load = 1'b0; #1;
        chk("wrap_addr0", 64'(w_addr), 64'hFC);
        tick(); #1;
        chk("wrap_addr1", 64'(w_addr), 64'h00);
        chk("wrap_out_pc", 64'(w_out_pc), 64'hFC);
        chk("wrap_pcp4", 64'(w_out_pcp4), 64'h00);
        chk("wrap_ins", 64'(w_out_ins), 64'hC0DE_00FC);
        chk("wrap_fault", 64'(w_fault), 64'd0);

        // Reset mid-transaction drops the pending request at once
        tick(); out_ready = 1'b0; imem_ack = 1'b0; load_entry = 1'b1; entry_point = 32'h40;
        tick(); load_entry = 1'b0; #1;
        chk("mid_req", 64'(imem_req), 64'd1);
        mon_en = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_req", 64'(imem_req), 64'd0);
        chk("mid_rst_count", 64'(count), 64'd0);
        chk("mid_rst_addr", 64'(imem_addr), 64'h80);
        chk("mid_rst_valid", 64'(out_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
